// File: rtl/stq_data_bank.sv
// Store-queue data array: DEPTH entries of WIDTH bits with per-byte valid state,
// two byte-enabled write ports, per-entry clear and NCHK registered check ports.
module stq_data_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int NCHK  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DEPTH-1:0]        wrt0_en,
  input  logic [WIDTH/8-1:0]      wrt0_be,
  input  logic [WIDTH-1:0]        wrt0_data,
  input  logic [DEPTH-1:0]        wrt1_en,
  input  logic [WIDTH/8-1:0]      wrt1_be,
  input  logic [WIDTH-1:0]        wrt1_data,
  input  logic [DEPTH-1:0]        clr_en,
  input  logic [NCHK*DEPTH-1:0]   chk_en,
  output logic [NCHK*WIDTH-1:0]   chk_data,
  output logic [NCHK*WIDTH/8-1:0] chk_be,
  output logic [NCHK-1:0]         chk_hit,
  output logic [NCHK-1:0]         chk_err,
  output logic [DEPTH-1:0]        valid
);

  localparam int BW = WIDTH / 8;

  function automatic logic [WIDTH-1:0] byte_mask(input logic [BW-1:0] be);
    logic [WIDTH-1:0] m;
    for (int b = 0; b < BW; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

  logic [WIDTH-1:0]      data_r     [DEPTH];
  logic [BW-1:0]         bv_r       [DEPTH];
  logic [WIDTH-1:0]      data_nxt_s [DEPTH];
  logic [BW-1:0]         bv_nxt_s   [DEPTH];
  logic [NCHK*WIDTH-1:0] rd_data_s;
  logic [NCHK*BW-1:0]    rd_be_s;
  logic [NCHK-1:0]       rd_hit_s;
  logic [NCHK-1:0]       rd_err_s;

  // Next entry state: clear first, then port 0 bytes, then port 1 bytes on top.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int b = 0; b < BW; b++) begin
        data_nxt_s[i][8*b +: 8] = (wrt1_en[i] && wrt1_be[b]) ? wrt1_data[8*b +: 8] :
                                  (wrt0_en[i] && wrt0_be[b]) ? wrt0_data[8*b +: 8] :
                                  data_r[i][8*b +: 8];
        bv_nxt_s[i][b] = (wrt0_en[i] && wrt0_be[b]) || (wrt1_en[i] && wrt1_be[b]) ||
                         (bv_r[i][b] && !clr_en[i]);
      end
    end
  end

  for (genvar k = 0; k < NCHK; k++) begin : g_chk
    logic [DEPTH-1:0] sel_s;
    logic [WIDTH-1:0] acc_data_s;
    logic [BW-1:0]    acc_be_s;
    logic             multi_s;

    assign sel_s   = chk_en[k*DEPTH +: DEPTH];
    assign multi_s = (sel_s & (sel_s - {{(DEPTH-1){1'b0}}, 1'b1})) != {DEPTH{1'b0}};

    // Wired-OR read of the post-update state so same-cycle writes are bypassed.
    always_comb begin
      acc_data_s = {WIDTH{1'b0}};
      acc_be_s   = {BW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        acc_data_s = acc_data_s | (data_nxt_s[i] & byte_mask(bv_nxt_s[i]) & {WIDTH{sel_s[i]}});
        acc_be_s   = acc_be_s | (bv_nxt_s[i] & {BW{sel_s[i]}});
      end
    end

    assign rd_data_s[k*WIDTH +: WIDTH] = acc_data_s;
    assign rd_be_s[k*BW +: BW]         = acc_be_s;
    assign rd_hit_s[k] = (sel_s != {DEPTH{1'b0}}) && !multi_s && (acc_be_s != {BW{1'b0}});
    assign rd_err_s[k] = multi_s;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    assign valid[i] = |bv_r[i];
  end

  // Byte-valid state and registered check results.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bv_r[i] <= {BW{1'b0}};
      end
      chk_data <= {(NCHK*WIDTH){1'b0}};
      chk_be   <= {(NCHK*BW){1'b0}};
      chk_hit  <= {NCHK{1'b0}};
      chk_err  <= {NCHK{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        bv_r[i] <= bv_nxt_s[i];
      end
      chk_data <= rd_data_s;
      chk_be   <= rd_be_s;
      chk_hit  <= rd_hit_s;
      chk_err  <= rd_err_s;
    end
  end

  // Data storage has no reset; bytes are only visible once their valid bit is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= data_nxt_s[i];
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= data_r[i];
      end
    end
  end

  stq_data_bank_chk #(.DEPTH(DEPTH)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .wrt0_en (wrt0_en),
    .wrt1_en (wrt1_en)
  );

endmodule

// Protocol checks: each write port selects at most one entry per cycle.
module stq_data_bank_chk #(
  parameter int DEPTH = 64
) (
  input logic             clk,
  input logic             rst,
  input logic [DEPTH-1:0] wrt0_en,
  input logic [DEPTH-1:0] wrt1_en
);

  a_wrt0_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(wrt0_en));
  a_wrt1_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(wrt1_en));

endmodule

// File: tb/tb_stq_data_bank.sv
// Directed bench for stq_data_bank: byte-level reference model compared every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_stq_data_bank;

  localparam int WIDTH = 32;
  localparam int DEPTH = 64;
  localparam int NCHK  = 8;
  localparam int BW    = WIDTH / 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [DEPTH-1:0]      wrt0_en, wrt1_en, clr_en;
  logic [BW-1:0]         wrt0_be, wrt1_be;
  logic [WIDTH-1:0]      wrt0_data, wrt1_data;
  logic [NCHK*DEPTH-1:0] chk_en;
  logic [NCHK*WIDTH-1:0] chk_data;
  logic [NCHK*BW-1:0]    chk_be;
  logic [NCHK-1:0]       chk_hit, chk_err;
  logic [DEPTH-1:0]      valid;

  stq_data_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCHK(NCHK)) dut (
    .clk(clk), .rst(rst),
    .wrt0_en(wrt0_en), .wrt0_be(wrt0_be), .wrt0_data(wrt0_data),
    .wrt1_en(wrt1_en), .wrt1_be(wrt1_be), .wrt1_data(wrt1_data),
    .clr_en(clr_en), .chk_en(chk_en),
    .chk_data(chk_data), .chk_be(chk_be), .chk_hit(chk_hit), .chk_err(chk_err),
    .valid(valid)
  );

  always #5 clk = ~clk;

  // reference model: bytes and byte-valid bits per entry
  logic [7:0]            m_byte [DEPTH][BW];
  bit                    m_bv   [DEPTH][BW];
  logic [NCHK*WIDTH-1:0] exp_data;
  logic [NCHK*BW-1:0]    exp_be;
  logic [NCHK-1:0]       exp_hit, exp_err;
  logic [DEPTH-1:0]      exp_valid;
  bit                    cmp_on = 1'b0;
  int                    n_cmp = 0;
  int                    n_bad = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_apply();
    int cnt;
    logic [WIDTH-1:0] d;
    logic [BW-1:0] be;
    if (!rst) begin
      for (int e = 0; e < DEPTH; e++)
        for (int b = 0; b < BW; b++) m_bv[e][b] = 1'b0;
      exp_data = '0; exp_be = '0; exp_hit = '0; exp_err = '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (clr_en[e])
          for (int b = 0; b < BW; b++) m_bv[e][b] = 1'b0;
        for (int b = 0; b < BW; b++) begin
          if (wrt0_en[e] && wrt0_be[b]) begin m_byte[e][b] = wrt0_data[8*b +: 8]; m_bv[e][b] = 1'b1; end
          if (wrt1_en[e] && wrt1_be[b]) begin m_byte[e][b] = wrt1_data[8*b +: 8]; m_bv[e][b] = 1'b1; end
        end
      end
      for (int k = 0; k < NCHK; k++) begin
        cnt = 0; d = '0; be = '0;
        for (int e = 0; e < DEPTH; e++) begin
          if (chk_en[k*DEPTH + e]) begin
            cnt++;
            for (int b = 0; b < BW; b++)
              if (m_bv[e][b]) begin d[8*b +: 8] = d[8*b +: 8] | m_byte[e][b]; be[b] = 1'b1; end
          end
        end
        exp_data[k*WIDTH +: WIDTH] = d;
        exp_be[k*BW +: BW] = be;
        exp_hit[k] = (cnt == 1) && (be != '0);
        exp_err[k] = (cnt > 1);
      end
    end
    for (int e = 0; e < DEPTH; e++) begin
      exp_valid[e] = 1'b0;
      for (int b = 0; b < BW; b++) exp_valid[e] = exp_valid[e] | m_bv[e][b];
    end
  endtask

  // compare DUT against the model on every falling edge once reset has run
  always @(negedge clk) begin
    if (cmp_on) begin
      check("model chk_data", chk_data, exp_data);
      check("model chk_be",   chk_be,   exp_be);
      check("model chk_hit",  chk_hit,  exp_hit);
      check("model chk_err",  chk_err,  exp_err);
      check("model valid",    valid,    exp_valid);
    end
  end

  task automatic idle();
    wrt0_en = '0; wrt0_be = '0; wrt0_data = '0;
    wrt1_en = '0; wrt1_be = '0; wrt1_data = '0;
    clr_en = '0; chk_en = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_apply();
    #1;
    idle();
  endtask

  task automatic wr0(input int e, input logic [BW-1:0] be, input logic [WIDTH-1:0] d);
    wrt0_en[e] = 1'b1; wrt0_be = be; wrt0_data = d;
  endtask

  task automatic wr1(input int e, input logic [BW-1:0] be, input logic [WIDTH-1:0] d);
    wrt1_en[e] = 1'b1; wrt1_be = be; wrt1_data = d;
  endtask

  task automatic sel(input int k, input int e);
    chk_en[k*DEPTH + e] = 1'b1;
  endtask

  initial begin
    for (int e = 0; e < DEPTH; e++)
      for (int b = 0; b < BW; b++) begin m_byte[e][b] = 8'h00; m_bv[e][b] = 1'b0; end
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    cmp_on = 1'b1;

    // reset then read
    sel(0, 5); tick();
    check("rst chk_data", chk_data[31:0], 32'h0);
    check("rst chk_be", chk_be[3:0], 4'h0);
    check("rst chk_hit", chk_hit[0], 1'b0);
    check("rst valid", valid, 64'h0);

    // byte merge across cycles
    wr0(3, 4'b0011, 32'hAABBCCDD); tick();
    wr0(3, 4'b1100, 32'h11223344); tick();
    sel(0, 3); tick();
    check("merge data", chk_data[31:0], 32'h1122CCDD);
    check("merge be", chk_be[3:0], 4'hF);
    check("merge hit", chk_hit[0], 1'b1);

    // same-cycle dual write, port 1 wins on overlap
    wr0(7, 4'hF, 32'h00000000); wr1(7, 4'b0010, 32'h0000EE00); tick();
    sel(2, 7); tick();
    check("dual data", chk_data[2*WIDTH +: WIDTH], 32'h0000EE00);
    check("dual be", chk_be[2*BW +: BW], 4'hF);

    // same-cycle write bypass into check
    wr0(9, 4'hF, 32'hDEADBEEF); sel(1, 9); tick();
    check("bypass data", chk_data[WIDTH +: WIDTH], 32'hDEADBEEF);
    check("bypass hit", chk_hit[1], 1'b1);

    // clear and write in the same cycle reallocates the entry
    wr1(2, 4'hF, 32'h12345678); tick();
    clr_en[2] = 1'b1; wr0(2, 4'b0001, 32'h000000AB); tick();
    sel(0, 2); tick();
    check("realloc be", chk_be[3:0], 4'b0001);
    check("realloc data", chk_data[31:0], 32'h000000AB);
    check("realloc valid", valid[2], 1'b1);
    clr_en[2] = 1'b1; tick();
    sel(0, 2); tick();
    check("clear valid", valid[2], 1'b0);
    check("clear hit", chk_hit[0], 1'b0);

    // multi-hot check and independent ports on the same entry
    wr0(1, 4'hF, 32'h000000F0); wr1(4, 4'hF, 32'h0000000F); tick();
    sel(0, 1); sel(0, 4); sel(3, 1); sel(7, 1); tick();
    check("multi err", chk_err[0], 1'b1);
    check("multi hit", chk_hit[0], 1'b0);
    check("multi data", chk_data[31:0], 32'h000000FF);
    check("port3 hit", chk_hit[3], 1'b1);
    check("port3 data", chk_data[3*WIDTH +: WIDTH], 32'h000000F0);

    // assorted partial writes read back on every port
    for (int k = 0; k < NCHK; k++) begin
      wr0(20 + k, 4'(k + 1), 32'h01020304 * (k + 1));
      if (k % 2 == 1) wr1(20 + k, 4'b1000, 32'hA5000000);
      sel(k, 20 + k);
      if (k > 0) sel(k - 1, 20 + k);
      tick();
    end

    // reset mid-operation discards the in-flight check
    sel(0, 3); sel(5, 9); rst = 1'b0; tick();
    rst = 1'b1;
    check("midrst hit", chk_hit, 8'h0);
    check("midrst valid", valid, 64'h0);
    sel(0, 3); tick();
    check("post rst data", chk_data[31:0], 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
